// File: rtl/trivium_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trivium_pkg
// Description : Shared constants, register map and state encoding for the
//               Trivium stream-cipher peripheral.
// Contents    : widths (key/IV 80, state 288, word 32), CE register indices,
//               CTRL bit positions, initialisation cycle count, FSM enum.
// Revision    : 1.0 - initial release
// ============================================================================
package trivium_pkg;

    localparam int KEY_W_c   = 80;
    localparam int STATE_W_c = 288;
    localparam int WORD_W_c  = 32;

    // Register map: CE bit index equals register address.
    localparam int CTRL_REG_ADDR_c  = 0;
    localparam int KEY_REG_0_ADDR_c = 1;
    localparam int IV_REG_0_ADDR_c  = 4;
    localparam int IN_REG_ADDR_c    = 7;
    localparam int OUT_REG_ADDR_c   = 8;
    localparam int NUM_REGS_c       = 9;

    // CTRL bit positions.
    localparam int INIT_BIT_POS_c       = 0;
    localparam int STOP_BIT_POS_c       = 1;
    localparam int DATA_AVAIL_BIT_POS_c = 8;
    localparam int READY_BIT_POS_c      = 9;

    // 36 cycles x 32 rounds = 1152 warm-up rounds.
    localparam int INIT_CYCLES_c = 36;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INIT_RUN = 2'd1,
        ST_RUN      = 2'd2
    } trivium_state_e;

endpackage : trivium_pkg
`default_nettype wire

// File: rtl/trivium_core.sv
`default_nettype none
// ============================================================================
// Module      : trivium_core
// Description : 288-bit Trivium state with key/IV load and a 32-round
//               unrolled update producing 32 keystream bits per advance.
// Ports       : clk_i, rst_i      - clock, synchronous active-high reset
//               load_i            - load state from key_i / iv_i
//               advance_i         - step the state by 32 rounds
//               key_i, iv_i [79:0]- key and IV
//               ks_o [31:0]       - keystream of the next 32 rounds,
//                                   bit j = j-th keystream bit
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_core
    import trivium_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic [KEY_W_c-1:0]    key_i,
    input  logic [KEY_W_c-1:0]    iv_i,
    output logic [WORD_W_c-1:0]   ks_o
);

    // Bit k of the vector holds Trivium state bit s(k+1).
    logic [STATE_W_c-1:0] state_q;
    logic [STATE_W_c-1:0] state_d;
    logic [STATE_W_c-1:0] load_d;
    logic [WORD_W_c-1:0]  ks_d;

    always_comb begin
        load_d           = '0;
        load_d[79:0]     = key_i;
        load_d[172:93]   = iv_i;
        load_d[287:285]  = 3'b111;
    end

    always_comb begin
        logic t1;
        logic t2;
        logic t3;
        state_d = state_q;
        ks_d    = '0;
        for (int r = 0; r < WORD_W_c; r++) begin
            t1 = state_d[65]  ^ state_d[92];
            t2 = state_d[161] ^ state_d[176];
            t3 = state_d[242] ^ state_d[287];
            ks_d[r] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (state_d[90]  & state_d[91])  ^ state_d[170];
            t2 = t2 ^ (state_d[174] & state_d[175]) ^ state_d[263];
            t3 = t3 ^ (state_d[285] & state_d[286]) ^ state_d[68];
            // Three shift registers: s1..s93, s94..s177, s178..s288.
            state_d = {state_d[286:177], t2, state_d[175:93], t1, state_d[91:0], t3};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
        end else if (load_i) begin
            state_q <= load_d;
        end else if (advance_i) begin
            state_q <= state_d;
        end
    end

    assign ks_o = ks_d;

endmodule : trivium_core
`default_nettype wire

// File: rtl/trivium_top_ip.sv
`default_nettype none
// ============================================================================
// Module      : trivium_top_ip
// Description : IPIF-style register slave around a Trivium keystream core.
//               Plaintext written to IN comes back XORed with keystream in
//               OUT, 32 bits per word.
// Ports       : bus2ip_clk_i, bus2ip_rst_i  - clock, sync active-high reset
//               bus2ip_addr_i, bus2ip_rnw_i - informational only
//               bus2ip_dat_i, bus2ip_be_i   - write data / byte enables
//               bus2ip_rdce_i, bus2ip_wrce_i- one-hot chip enables (9 regs)
//               ip2bus_dat_o                - read data (0 when no rdack)
//               ip2bus_rdack_o, ip2bus_wrack_o, ip2bus_err_o
// Config      : TRIVIUM_KEY_READBACK_EN - KEY/IV registers readable;
//               otherwise they read as 0.
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_top_ip
    import trivium_pkg::*;
(
    input  logic        bus2ip_clk_i,
    input  logic        bus2ip_rst_i,
    input  logic [3:0]  bus2ip_addr_i,
    input  logic        bus2ip_rnw_i,
    input  logic [31:0] bus2ip_dat_i,
    input  logic [3:0]  bus2ip_be_i,
    input  logic [8:0]  bus2ip_rdce_i,
    input  logic [8:0]  bus2ip_wrce_i,
    output logic [31:0] ip2bus_dat_o,
    output logic        ip2bus_rdack_o,
    output logic        ip2bus_wrack_o,
    output logic        ip2bus_err_o
);

    trivium_state_e        state_q;
    logic [5:0]            cnt_q;
    logic [KEY_W_c-1:0]    key_q;
    logic [KEY_W_c-1:0]    iv_q;
    logic [WORD_W_c-1:0]   in_q;
    logic [WORD_W_c-1:0]   out_q;
    logic [WORD_W_c-1:0]   ct_q;
    logic                  ct_vld_q;
    logic                  pending_q;
    logic                  avail_q;
    logic                  wr_busy_q;
    logic                  rd_busy_q;
    logic                  wrack_q;
    logic                  rdack_q;
    logic                  err_q;
    logic [31:0]           rdat_q;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [NUM_REGS_c-1:0] wr_sel;
    logic [NUM_REGS_c-1:0] rd_sel;
    logic                  ctrl_wr;
    logic                  stop_req;
    logic                  init_req;
    logic                  consume;
    logic                  advance;
    logic [WORD_W_c-1:0]   ks;
    logic [31:0]           rd_mux_d;
    logic                  unused_ok;

    assign unused_ok = ^{bus2ip_addr_i, bus2ip_rnw_i, bus2ip_be_i[3:1]};

    // An access is the first cycle a CE is seen; a CE held high afterwards
    // is not a new access until it has dropped for at least one cycle.
    assign wr_acc = (|bus2ip_wrce_i) && !wr_busy_q;
    assign rd_acc = (|bus2ip_rdce_i) && !rd_busy_q;
    assign wr_sel = bus2ip_wrce_i & {NUM_REGS_c{wr_acc && $onehot(bus2ip_wrce_i)}};
    assign rd_sel = bus2ip_rdce_i & {NUM_REGS_c{rd_acc && $onehot(bus2ip_rdce_i)}};

    assign ctrl_wr  = wr_sel[CTRL_REG_ADDR_c] && bus2ip_be_i[0];
    assign stop_req = ctrl_wr && bus2ip_dat_i[STOP_BIT_POS_c];
    assign init_req = ctrl_wr && bus2ip_dat_i[INIT_BIT_POS_c] && !bus2ip_dat_i[STOP_BIT_POS_c]
                      && (state_q == ST_IDLE);
    assign consume  = (state_q == ST_RUN) && pending_q && !stop_req;
    assign advance  = (state_q == ST_INIT_RUN) || consume;

    trivium_core u_core (
        .clk_i     (bus2ip_clk_i),
        .rst_i     (bus2ip_rst_i),
        .load_i    (init_req),
        .advance_i (advance),
        .key_i     (key_q),
        .iv_i      (iv_q),
        .ks_o      (ks)
    );

    always_comb begin
        rd_mux_d = '0;
        if (bus2ip_rdce_i[CTRL_REG_ADDR_c]) begin
            rd_mux_d[READY_BIT_POS_c]      = (state_q == ST_IDLE);
            rd_mux_d[DATA_AVAIL_BIT_POS_c] = avail_q;
        end
        if (bus2ip_rdce_i[OUT_REG_ADDR_c]) begin
            rd_mux_d = out_q;
        end
`ifdef TRIVIUM_KEY_READBACK_EN
        if (bus2ip_rdce_i[KEY_REG_0_ADDR_c])     rd_mux_d = key_q[31:0];
        if (bus2ip_rdce_i[KEY_REG_0_ADDR_c + 1]) rd_mux_d = key_q[63:32];
        if (bus2ip_rdce_i[KEY_REG_0_ADDR_c + 2]) rd_mux_d = {16'h0000, key_q[79:64]};
        if (bus2ip_rdce_i[IV_REG_0_ADDR_c])      rd_mux_d = iv_q[31:0];
        if (bus2ip_rdce_i[IV_REG_0_ADDR_c + 1])  rd_mux_d = iv_q[63:32];
        if (bus2ip_rdce_i[IV_REG_0_ADDR_c + 2])  rd_mux_d = {16'h0000, iv_q[79:64]};
`endif
    end

    always_ff @(posedge bus2ip_clk_i) begin
        if (bus2ip_rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            key_q     <= '0;
            iv_q      <= '0;
            in_q      <= '0;
            out_q     <= '0;
            ct_q      <= '0;
            ct_vld_q  <= 1'b0;
            pending_q <= 1'b0;
            avail_q   <= 1'b0;
            wr_busy_q <= 1'b0;
            rd_busy_q <= 1'b0;
            wrack_q   <= 1'b0;
            rdack_q   <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= '0;
        end else begin
            wr_busy_q <= |bus2ip_wrce_i;
            rd_busy_q <= |bus2ip_rdce_i;
            wrack_q   <= wr_acc;
            rdack_q   <= rd_acc;
            err_q     <= (wr_acc && !$onehot(bus2ip_wrce_i)) ||
                         (rd_acc && !$onehot(bus2ip_rdce_i));
            rdat_q    <= (|rd_sel) ? rd_mux_d : 32'h0;

            if (wr_sel[KEY_REG_0_ADDR_c])     key_q[31:0]  <= bus2ip_dat_i;
            if (wr_sel[KEY_REG_0_ADDR_c + 1]) key_q[63:32] <= bus2ip_dat_i;
            if (wr_sel[KEY_REG_0_ADDR_c + 2]) key_q[79:64] <= bus2ip_dat_i[15:0];
            if (wr_sel[IV_REG_0_ADDR_c])      iv_q[31:0]   <= bus2ip_dat_i;
            if (wr_sel[IV_REG_0_ADDR_c + 1])  iv_q[63:32]  <= bus2ip_dat_i;
            if (wr_sel[IV_REG_0_ADDR_c + 2])  iv_q[79:64]  <= bus2ip_dat_i[15:0];

            // A new IN word beats consumption of the previous one.
            if (wr_sel[IN_REG_ADDR_c]) begin
                in_q      <= bus2ip_dat_i;
                pending_q <= 1'b1;
            end else if (consume) begin
                pending_q <= 1'b0;
            end

            // Ciphertext is staged one cycle before it lands in OUT.
            ct_vld_q <= consume;
            if (consume) begin
                ct_q <= in_q ^ ks;
            end

            // New-word set wins over the OUT-read clear.
            if (ct_vld_q) begin
                out_q   <= ct_q;
                avail_q <= 1'b1;
            end else if (rd_sel[OUT_REG_ADDR_c]) begin
                avail_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (init_req) begin
                        state_q <= ST_INIT_RUN;
                        cnt_q   <= '0;
                    end
                end
                ST_INIT_RUN: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(INIT_CYCLES_c - 1)) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (stop_req) begin
                state_q   <= ST_IDLE;
                pending_q <= 1'b0;
                ct_vld_q  <= 1'b0;
                avail_q   <= 1'b0;
                out_q     <= out_q;
            end
        end
    end

    assign ip2bus_dat_o   = rdat_q;
    assign ip2bus_rdack_o = rdack_q;
    assign ip2bus_wrack_o = wrack_q;
    assign ip2bus_err_o   = err_q;

endmodule : trivium_top_ip
`default_nettype wire

// File: tb/tb_trivium_top_ip.sv
`default_nettype none
// ============================================================================
// Module      : tb_trivium_top_ip
// Description : Self-checking bench for trivium_top_ip. Keystream expectations
//               come from a bit-serial Trivium model over a 1-based bit array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trivium_top_ip;

    logic        clk;
    logic        rst;
    logic [3:0]  addr;
    logic        rnw;
    logic [31:0] wdat;
    logic [3:0]  be;
    logic [8:0]  rdce;
    logic [8:0]  wrce;
    logic [31:0] rdat;
    logic        rdack;
    logic        wrack;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    trivium_top_ip dut (
        .bus2ip_clk_i   (clk),
        .bus2ip_rst_i   (rst),
        .bus2ip_addr_i  (addr),
        .bus2ip_rnw_i   (rnw),
        .bus2ip_dat_i   (wdat),
        .bus2ip_be_i    (be),
        .bus2ip_rdce_i  (rdce),
        .bus2ip_wrce_i  (wrce),
        .ip2bus_dat_o   (rdat),
        .ip2bus_rdack_o (rdack),
        .ip2bus_wrack_o (wrack),
        .ip2bus_err_o   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model (bit-serial Trivium) ----------------
    bit m_s [1:288];

    function automatic bit m_bit();
        bit t1, t2, t3, z;
        t1 = m_s[66]  ^ m_s[93];
        t2 = m_s[162] ^ m_s[177];
        t3 = m_s[243] ^ m_s[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (m_s[91]  & m_s[92])  ^ m_s[171];
        t2 = t2 ^ (m_s[175] & m_s[176]) ^ m_s[264];
        t3 = t3 ^ (m_s[286] & m_s[287]) ^ m_s[69];
        for (int i = 93; i >= 2; i--)   m_s[i] = m_s[i-1];
        m_s[1] = t3;
        for (int i = 177; i >= 95; i--) m_s[i] = m_s[i-1];
        m_s[94] = t1;
        for (int i = 288; i >= 179; i--) m_s[i] = m_s[i-1];
        m_s[178] = t2;
        return z;
    endfunction

    task automatic m_init(input logic [79:0] k, input logic [79:0] v);
        bit z;
        for (int i = 1; i <= 288; i++) m_s[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            m_s[i+1]  = k[i];
            m_s[94+i] = v[i];
        end
        m_s[286] = 1'b1;
        m_s[287] = 1'b1;
        m_s[288] = 1'b1;
        for (int i = 0; i < 1152; i++) z = m_bit();
    endtask

    function automatic logic [31:0] m_word();
        logic [31:0] w;
        for (int j = 0; j < 32; j++) w[j] = m_bit();
        return w;
    endfunction

    // ---------------- bus helpers ----------------
    logic [31:0] g_rd;
    logic        g_ack;
    logic        g_err;

    task automatic bus_acc(input bit is_rd, input logic [8:0] ce, input logic [31:0] d,
                           input logic [3:0] bytes);
        @(negedge clk);
        addr = 4'd0;
        for (int i = 8; i >= 0; i--) if (ce[i]) addr = 4'(i);
        rnw  = is_rd;
        wdat = d;
        be   = bytes;
        if (is_rd) rdce = ce; else wrce = ce;
        @(posedge clk);
        #1;
        g_ack = is_rd ? rdack : wrack;
        g_err = err;
        g_rd  = rdat;
        @(negedge clk);
        rdce = '0;
        wrce = '0;
        @(posedge clk);
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        bus_acc(1'b0, 9'(1 << idx), d, 4'hF);
        check_eq("wrack", {31'b0, g_ack}, 32'd1);
    endtask

    task automatic rd(input int idx, output logic [31:0] d);
        bus_acc(1'b1, 9'(1 << idx), 32'h0, 4'hF);
        check_eq("rdack", {31'b0, g_ack}, 32'd1);
        d = g_rd;
    endtask

    task automatic load_key_iv(input logic [79:0] k, input logic [79:0] v);
        wr(1, k[31:0]);
        wr(2, k[63:32]);
        wr(3, {16'($urandom), k[79:64]});
        wr(4, v[31:0]);
        wr(5, v[63:32]);
        wr(6, {16'($urandom), v[79:64]});
    endtask

    task automatic wait_avail();
        logic [31:0] c;
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            rd(0, c);
            found = c[8];
        end
        check_eq("avail_wait", {31'b0, found}, 32'd1);
    endtask

    // Feed one word (optionally already written), return DUT output.
    task automatic crypt(input bit do_write, input logic [31:0] pt, output logic [31:0] ct);
        logic [31:0] c;
        if (do_write) wr(7, pt);
        wait_avail();
        rd(8, ct);
        rd(0, c);
        check_eq("avail_clr", c & 32'h100, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] v, ct, pt;
        logic [79:0] k, iv;
        logic [31:0] pts [4];
        logic [31:0] cts [4];
        int          acks;

        rst = 1'b1; addr = '0; rnw = 1'b0; wdat = '0; be = '0; rdce = '0; wrce = '0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_rdack", {31'b0, rdack}, 32'd0);
        check_eq("rst_wrack", {31'b0, wrack}, 32'd0);
        check_eq("rst_err",   {31'b0, err},   32'd0);
        check_eq("rst_dat",   rdat,           32'd0);
        @(negedge clk);
        rst = 1'b0;

        acks = 0;
        repeat (5) begin
            @(posedge clk); #1;
            acks += int'(rdack) + int'(wrack);
        end
        check_eq("no_ce_acks", 32'(acks), 32'd0);
        rd(0, v); check_eq("rst_ctrl", v, 32'h200);
        rd(8, v); check_eq("rst_out",  v, 32'h0);

        // Held write CE produces a single acknowledge.
        @(negedge clk);
        wdat = 32'h12345678; be = 4'hF; wrce = 9'h002; addr = 4'd1;
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            acks += int'(wrack);
        end
        @(negedge clk); wrce = '0;
        repeat (2) begin
            @(posedge clk); #1;
            acks += int'(wrack);
        end
        check_eq("held_ce_acks", 32'(acks), 32'd1);
        rd(1, v);
`ifdef TRIVIUM_KEY_READBACK_EN
        check_eq("key0_rb", v, 32'h12345678);
`else
        check_eq("key0_rb", v, 32'h0);
`endif

        // Zero key / IV, first keystream word.
        load_key_iv(80'h0, 80'h0);
        m_init(80'h0, 80'h0);
        wr(0, 32'h1);
        rd(0, v); check_eq("ready_low", v, 32'h0);
        crypt(1'b1, 32'h0, ct);
        check_eq("zero_ks0", ct, m_word());
        rd(8, v); check_eq("out_hold", v, ct);

        // Round trip with key 0x80..00.
        k = 80'h8000_0000_0000_0000_0000;
        iv = 80'h0;
        wr(0, 32'h2);
        rd(0, v); check_eq("stop_ctrl", v, 32'h200);
        load_key_iv(k, iv);
        m_init(k, iv);
        wr(0, 32'h1);
        for (int i = 0; i < 4; i++) begin
            pts[i] = $urandom;
            crypt(1'b1, pts[i], cts[i]);
            check_eq("rt_enc", cts[i], pts[i] ^ m_word());
        end
        wr(0, 32'h2);
        rd(0, v); check_eq("stop_idle", v, 32'h200);
        wr(0, 32'h1);
        for (int i = 0; i < 4; i++) begin
            crypt(1'b1, cts[i], pt);
            check_eq("rt_dec", pt, pts[i]);
        end

        // Randomised keys and IVs.
        for (int t = 0; t < 4; t++) begin
            wr(0, 32'h2);
            k  = {16'($urandom), $urandom, $urandom};
            iv = {16'($urandom), $urandom, $urandom};
            load_key_iv(k, iv);
`ifdef TRIVIUM_KEY_READBACK_EN
            rd(3, v); check_eq("key2_rb", v, {16'h0, k[79:64]});
            rd(5, v); check_eq("iv1_rb",  v, iv[63:32]);
`endif
            m_init(k, iv);
            pt = $urandom;
            if (t == 0) begin
                // Word written in IDLE waits for RUN.
                wr(7, pt);
                wr(0, 32'h1);
                crypt(1'b0, pt, ct);
            end else if (t == 1) begin
                // Second write before consumption replaces the first.
                wr(0, 32'h1);
                wr(7, ~pt);
                wr(7, pt);
                crypt(1'b0, pt, ct);
            end else begin
                wr(0, 32'h1);
                crypt(1'b1, pt, ct);
            end
            check_eq("rand_w0", ct, pt ^ m_word());
            // INIT while running must not reload the state.
            wr(0, 32'h1);
            for (int w = 0; w < 2 + (t % 2); w++) begin
                pt = $urandom;
                crypt(1'b1, pt, ct);
                check_eq("rand_wn", ct, pt ^ m_word());
            end
        end

        // CTRL corner cases.
        wr(0, 32'h2);
        wr(0, 32'h3);
        rd(0, v); check_eq("init_stop", v, 32'h200);
        bus_acc(1'b0, 9'h001, 32'h1, 4'h0);
        check_eq("be0_wrack", {31'b0, g_ack}, 32'd1);
        rd(0, v); check_eq("be0_ctrl", v, 32'h200);

        // Multi-CE accesses are rejected with err.
        wr(1, 32'hCAFE0001);
        bus_acc(1'b0, 9'h003, 32'h1, 4'hF);
        check_eq("multi_wr_err",  {31'b0, g_err}, 32'd1);
        check_eq("multi_wr_ack",  {31'b0, g_ack}, 32'd1);
        rd(0, v); check_eq("multi_wr_ctrl", v, 32'h200);
        rd(1, v);
`ifdef TRIVIUM_KEY_READBACK_EN
        check_eq("multi_wr_key0", v, 32'hCAFE0001);
`else
        check_eq("multi_wr_key0", v, 32'h0);
`endif
        bus_acc(1'b1, 9'h101, 32'h0, 4'hF);
        check_eq("multi_rd_err", {31'b0, g_err}, 32'd1);
        check_eq("multi_rd_ack", {31'b0, g_ack}, 32'd1);
        check_eq("multi_rd_dat", g_rd, 32'h0);
        wr(2, 32'h0);
        check_eq("single_err", {31'b0, g_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_trivium_top_ip
`default_nettype wire
